// File: rtl/mii_frame_gen_check.sv
// Loopback bring-up block: 64b/8b MII frame generator plus a protocol checker that
// watches the generated stream and pulses payload, inter-packet-gap and framing errors.
module mii_frame_gen_check #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int PAYLOAD_WORDS = 8,
    parameter int IPG_WORDS     = 2,
    parameter int MIN_IPG_WORDS = 2
) (
    input  logic                  clk,
    input  logic                  i_rst,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  payload_error,
    output logic                  intergap_error,
    output logic                  other_error
);
    localparam logic [DATA_WIDTH-1:0] IDLE_DATA  = 64'h0707070707070707;
    localparam logic [DATA_WIDTH-1:0] START_DATA = 64'hD5555555555555FB;
    localparam logic [DATA_WIDTH-1:0] TERM_DATA  = 64'h07070707070707FD;
    localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = 8'hFF;
    localparam logic [CTRL_WIDTH-1:0] CTRL_START = 8'h01;
    localparam logic [CTRL_WIDTH-1:0] CTRL_NONE  = 8'h00;

    typedef enum logic [1:0] {G_GAP, G_START, G_PAYLOAD, G_TERM} gen_state_t;
    typedef enum logic {C_IDLE, C_DATA} chk_state_t;

    gen_state_t            r_gen_state, w_gen_state_next;
    logic [7:0]            r_gen_cnt, w_gen_cnt_next;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_next, w_gen_pattern, w_chk_pattern;
    logic [CTRL_WIDTH-1:0] r_tx_ctrl, w_tx_ctrl_next;

    chk_state_t            r_chk_state, w_chk_state_next;
    logic [7:0]            r_gap_cnt, w_gap_cnt_next;
    logic [7:0]            r_word_cnt, w_word_cnt_next;
    logic                  r_seen_start, w_seen_start_next;
    logic                  r_payload_error, w_payload_error_next;
    logic                  r_intergap_error, w_intergap_error_next;
    logic                  r_other_error, w_other_error_next;
    logic                  w_is_idle, w_is_start, w_is_term, w_is_payload;

    // Lane i of payload word k carries (8k+i) mod 256; only the low 5 bits of k matter.
    for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
        assign w_gen_pattern[8*gi +: 8] = {r_gen_cnt[4:0], 3'b000} + 8'(gi);
        assign w_chk_pattern[8*gi +: 8] = {r_word_cnt[4:0], 3'b000} + 8'(gi);
    end

    always_comb begin
        w_gen_state_next = r_gen_state;
        w_gen_cnt_next   = r_gen_cnt;
        w_tx_data_next   = IDLE_DATA;
        w_tx_ctrl_next   = CTRL_ALL;
        case (r_gen_state)
            G_GAP: begin
                if (r_gen_cnt == 8'(IPG_WORDS - 1)) begin
                    w_gen_state_next = G_START;
                    w_gen_cnt_next   = 8'd0;
                end else begin
                    w_gen_cnt_next = r_gen_cnt + 8'd1;
                end
            end
            G_START: begin
                w_tx_data_next   = START_DATA;
                w_tx_ctrl_next   = CTRL_START;
                w_gen_state_next = G_PAYLOAD;
                w_gen_cnt_next   = 8'd0;
            end
            G_PAYLOAD: begin
                w_tx_data_next = w_gen_pattern;
                w_tx_ctrl_next = CTRL_NONE;
                if (r_gen_cnt == 8'(PAYLOAD_WORDS - 1)) begin
                    w_gen_state_next = G_TERM;
                    w_gen_cnt_next   = 8'd0;
                end else begin
                    w_gen_cnt_next = r_gen_cnt + 8'd1;
                end
            end
            default: begin
                w_tx_data_next   = TERM_DATA;
                w_gen_state_next = G_GAP;
                w_gen_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_gen_state <= G_GAP;
            r_gen_cnt   <= 8'd0;
            r_tx_data   <= IDLE_DATA;
            r_tx_ctrl   <= CTRL_ALL;
        end else begin
            r_gen_state <= w_gen_state_next;
            r_gen_cnt   <= w_gen_cnt_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_ctrl   <= w_tx_ctrl_next;
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_ctrl = r_tx_ctrl;

    // The checker decodes the output nets themselves so it sees exactly what leaves the block.
    assign w_is_idle    = (o_tx_data == IDLE_DATA)  && (o_tx_ctrl == CTRL_ALL);
    assign w_is_start   = (o_tx_data == START_DATA) && (o_tx_ctrl == CTRL_START);
    assign w_is_term    = (o_tx_data == TERM_DATA)  && (o_tx_ctrl == CTRL_ALL);
    assign w_is_payload = (o_tx_ctrl == CTRL_NONE);

    always_comb begin
        w_chk_state_next      = r_chk_state;
        w_gap_cnt_next        = r_gap_cnt;
        w_word_cnt_next       = r_word_cnt;
        w_seen_start_next     = r_seen_start;
        w_payload_error_next  = 1'b0;
        w_intergap_error_next = 1'b0;
        w_other_error_next    = 1'b0;
        case (r_chk_state)
            C_IDLE: begin
                if (w_is_idle) begin
                    if (r_gap_cnt != 8'hFF) w_gap_cnt_next = r_gap_cnt + 8'd1;
                end else if (w_is_start) begin
                    w_intergap_error_next = r_seen_start && (r_gap_cnt < 8'(MIN_IPG_WORDS));
                    w_chk_state_next      = C_DATA;
                    w_word_cnt_next       = 8'd0;
                    w_seen_start_next     = 1'b1;
                end else begin
                    w_other_error_next = 1'b1;
                end
            end
            default: begin
                if (w_is_payload) begin
                    w_payload_error_next = (o_tx_data != w_chk_pattern);
                    if (r_word_cnt != 8'hFF) w_word_cnt_next = r_word_cnt + 8'd1;
                end else if (w_is_term) begin
                    w_payload_error_next = (r_word_cnt != 8'(PAYLOAD_WORDS));
                    w_chk_state_next     = C_IDLE;
                    w_gap_cnt_next       = 8'd0;
                end else if (w_is_start) begin
                    w_other_error_next = 1'b1;
                    w_word_cnt_next    = 8'd0;
                end else begin
                    w_other_error_next = 1'b1;
                    w_chk_state_next   = C_IDLE;
                    w_gap_cnt_next     = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_chk_state      <= C_IDLE;
            r_gap_cnt        <= 8'd0;
            r_word_cnt       <= 8'd0;
            r_seen_start     <= 1'b0;
            r_payload_error  <= 1'b0;
            r_intergap_error <= 1'b0;
            r_other_error    <= 1'b0;
        end else begin
            r_chk_state      <= w_chk_state_next;
            r_gap_cnt        <= w_gap_cnt_next;
            r_word_cnt       <= w_word_cnt_next;
            r_seen_start     <= w_seen_start_next;
            r_payload_error  <= w_payload_error_next;
            r_intergap_error <= w_intergap_error_next;
            r_other_error    <= w_other_error_next;
        end
    end

    assign payload_error  = r_payload_error;
    assign intergap_error = r_intergap_error;
    assign other_error    = r_other_error;
endmodule

// File: tb/tb_mii_frame_gen_check.sv
// Randomized bench for mii_frame_gen_check: frame arithmetic and a stream-parser model
// feed an expectation queue that a negedge monitor drains and compares.
module tb_mii_frame_gen_check;
    localparam int PW     = 8;
    localparam int IPG    = 2;
    localparam int MINIPG = 2;
    localparam int PERIOD = IPG + PW + 2;
    localparam int NCYC   = 600;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [63:0] tx_data;
    logic [7:0]  tx_ctrl;
    logic        perr, gerr, oerr;

    always #5 clk = ~clk;

    mii_frame_gen_check #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .PAYLOAD_WORDS(PW),
        .IPG_WORDS(IPG), .MIN_IPG_WORDS(MINIPG)
    ) dut (
        .clk(clk), .i_rst(i_rst), .o_tx_data(tx_data), .o_tx_ctrl(tx_ctrl),
        .payload_error(perr), .intergap_error(gerr), .other_error(oerr)
    );

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic [7:0]  c;
        bit          chk_word;
        bit          pe, ge, oe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Stream-parser reference state
    bit m_in_frame, m_seen;
    int m_gap, m_words;

    function automatic void gen_word(input int p, output logic [63:0] d, output logic [7:0] c);
        d = IDLE_D;
        c = 8'hFF;
        if (p == IPG) begin
            d = START_D; c = 8'h01;
        end else if (p > IPG && p <= IPG + PW) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'((8 * (p - IPG - 1) + i) % 256);
            c = 8'h00;
        end else if (p == IPG + PW + 1) begin
            d = TERM_D; c = 8'hFF;
        end
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_seen = 0; m_gap = 0; m_words = 0;
    endtask

    task automatic model_check(input logic [63:0] d, input logic [7:0] c,
                               output bit pe, output bit ge, output bit oe);
        bit is_idle, is_start, is_term;
        is_idle  = (d == IDLE_D)  && (c == 8'hFF);
        is_start = (d == START_D) && (c == 8'h01);
        is_term  = (d == TERM_D)  && (c == 8'hFF);
        pe = 0; ge = 0; oe = 0;
        if (!m_in_frame) begin
            if (is_idle) begin
                m_gap = (m_gap < 255) ? m_gap + 1 : 255;
            end else if (is_start) begin
                ge = m_seen && (m_gap < MINIPG);
                m_in_frame = 1; m_words = 0; m_seen = 1;
            end else begin
                oe = 1;
            end
        end else begin
            if (c == 8'h00) begin
                for (int i = 0; i < 8; i++)
                    if (d[8*i +: 8] != 8'((8 * m_words + i) % 256)) pe = 1;
                m_words = (m_words < 255) ? m_words + 1 : 255;
            end else if (is_term) begin
                pe = (m_words != PW);
                m_in_frame = 0; m_gap = 0;
            end else if (is_start) begin
                oe = 1; m_words = 0;
            end else begin
                oe = 1; m_in_frame = 0; m_gap = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_word) begin
                n_checks++;
                if (tx_data !== e.d || tx_ctrl !== e.c) begin
                    n_fail++;
                    $display("FAIL tx_word cyc %0d: got %h/%h expected %h/%h",
                             e.cyc, tx_data, tx_ctrl, e.d, e.c);
                end
            end
            n_checks++;
            if ({perr, gerr, oerr} !== {e.pe, e.ge, e.oe}) begin
                n_fail++;
                $display("FAIL errors cyc %0d: got p/g/o=%b%b%b expected %b%b%b",
                         e.cyc, perr, gerr, oerr, e.pe, e.ge, e.oe);
            end
        end
    end

    initial begin
        int          t, fr, p, rand_p, kind;
        bit          rand_en, inj, forced, rst_next, pe_p, ge_p, oe_p;
        logic [63:0] exp_d, inj_d;
        logic [7:0]  exp_c, inj_c;
        exp_t        rec;

        t = -1; fr = 0; rand_p = 0; rand_en = 0; forced = 0;
        pe_p = 0; ge_p = 0; oe_p = 0;
        model_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (forced) begin
                release dut.o_tx_data;
                release dut.o_tx_ctrl;
                forced = 0;
            end
            p = (t >= 0) ? (t % PERIOD) : -1;
            if (p == 0) begin
                fr++;
                rand_p  = $urandom_range(0, PERIOD - 1);
                rand_en = ($urandom_range(0, 1) == 1);
            end
            if (t < 0) begin
                exp_d = IDLE_D; exp_c = 8'hFF;
            end else begin
                gen_word(p, exp_d, exp_c);
            end

            inj = 0; inj_d = exp_d; inj_c = exp_c;
            if (t >= 0) begin
                if (fr == 3 && p == IPG + 1 + 5) begin
                    inj = 1;
                    inj_d = exp_d ^ (64'($urandom_range(1, 255)) << 24);
                end else if (fr == 6 && p == 0) begin
                    inj = 1; inj_d = START_D; inj_c = 8'h01;
                end else if (fr == 9 && p == 0) begin
                    inj = 1; inj_d = TERM_D; inj_c = 8'hFF;
                end else if (fr == 11 && p == IPG + 3) begin
                    inj = 1; inj_c = 8'h0F;
                end else if (fr >= 14 && fr < 40 && rand_en && p == rand_p) begin
                    inj = 1;
                    kind = $urandom_range(0, 5);
                    case (kind)
                        0: begin inj_d = IDLE_D;  inj_c = 8'hFF; end
                        1: begin inj_d = START_D; inj_c = 8'h01; end
                        2: begin inj_d = TERM_D;  inj_c = 8'hFF; end
                        3: begin inj_d = {$urandom, $urandom}; inj_c = 8'h00; end
                        4: begin inj_d = {$urandom, $urandom}; inj_c = 8'h02; end
                        default: begin inj_d = 64'hFEFEFEFEFEFEFEFE; inj_c = 8'hFF; end
                    endcase
                end
            end
            rst_next = (t >= 0) && ((fr == 20 && p == IPG + 4) ||
                                    (fr == 33 && p == rand_p) ||
                                    (fr == 45 && p == IPG + PW + 1));

            rec.cyc = cyc; rec.d = exp_d; rec.c = exp_c; rec.chk_word = !inj;
            rec.pe = pe_p; rec.ge = ge_p; rec.oe = oe_p;
            q.push_back(rec);

            if (inj) begin
                force dut.o_tx_data = inj_d;
                force dut.o_tx_ctrl = inj_c;
                forced = 1;
            end

            i_rst = rst_next;
            if (rst_next) begin
                model_reset();
                pe_p = 0; ge_p = 0; oe_p = 0;
                t = -1;
            end else begin
                model_check(inj_d, inj_c, pe_p, ge_p, oe_p);
                t = t + 1;
            end
            @(posedge clk);
            #1;
        end

        if (forced) begin
            release dut.o_tx_data;
            release dut.o_tx_ctrl;
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
